display_sequencer: RTL and testbench
====================================

# display_sequencer

Registered controller generating `display_select` for the calculator's three-digit display mux. Source A is operand entry; source B is the last result. Switches between them on calculator events and user toggles, reverts to A after an idle timeout, and flags, and optionally blinks, an overflowed result. Sits between keypad/ALU control logic and the mux select pin.

## Interface
- `TIMEOUT_CYCLES`, default 250_000_000: cycles in SHOW_B with no event before auto-revert to A (5 s at 50 MHz). 0 disables auto-revert.
- `BLINK_HALF_CYCLES`, default 12_500_000: half-period of the error blink. Must be ≥1.
- `clk`  in  1  system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_press`  in  1  single-cycle pulse: new operand digit entered.
- `result_valid`  in  1  single-cycle pulse: ALU result latched into source B.
- `result_overflow`  in  1  qualifies `result_valid`: result out of 3-digit range.
- `view_toggle`  in  1  single-cycle debounced pulse: user swap request.
- `display_select`  out  1  0 = source A, 1 = source B. Drives the mux.
- `display_blank`  out  1  1 = blank all three digits.
- `error_active`  out  1  high while in SHOW_ERR.

## Operation
- States: SHOW_A (select 0), SHOW_B (select 1), SHOW_ERR (select 1, error_active 1).
- Internal `have_result` flag:
  - Set on `result_valid` without overflow.
  - Cleared on exit from SHOW_ERR and on reset.
- Event priority within one cycle: `result_valid` > `key_press` > `view_toggle`. Lower-priority events in the same cycle are dropped.
- SHOW_A:
  - `result_valid` & ~overflow → SHOW_B.
  - `result_valid` & overflow → SHOW_ERR.
  - `view_toggle` & `have_result` → SHOW_B.
  - `view_toggle` & ~`have_result` → ignored.
  - `key_press` → stay.
- SHOW_B:
  - `result_valid` & ~overflow → stay, and restart the timer.
  - `result_valid` & overflow → SHOW_ERR.
  - `key_press` or `view_toggle` → SHOW_A.
  - Timer reaching `TIMEOUT_CYCLES`-1 with no event → SHOW_A.
- SHOW_ERR:
  - `key_press` or `view_toggle` → SHOW_A.
  - `result_valid` & ~overflow → SHOW_B.
  - No timeout.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on every cycle not in SHOW_B and on any event.
  - Increments otherwise; saturates, never wraps.
- Blink counter: runs only in SHOW_ERR; cleared on entry.

## Timing
- All outputs are registered. Each responds on the clock edge that samples the event: 1-cycle latency from input pulse to output change.
- Reset values (asynchronous, immediate):
  - state SHOW_A; `display_select` 0; `display_blank` 0; `error_active` 0.
  - `have_result` 0; both counters 0.
- Reset asserted mid-operation (any state, any counter value) returns to the reset values immediately. First transition is possible on the first rising edge after `reset_n` deasserts.
- Auto-revert: entering SHOW_B at edge N with no further events gives `display_select` 0 after edge N+`TIMEOUT_CYCLES`.
- Blink: `display_blank` is 0 for the first `BLINK_HALF_CYCLES` cycles after SHOW_ERR entry, then toggles every `BLINK_HALF_CYCLES`. Forced 0 on exit, in the same cycle as the state change.
- Inputs are assumed synchronous to `clk`. Held (multi-cycle) pulses are treated as one event per cycle.

## Configuration
- `DISPLAY_SEQ_BLINK_EN` defined:
  - Blink counter and blink logic compiled in.
  - `display_blank` toggles in SHOW_ERR as specified.
- Undefined:
  - Blink counter absent; `display_blank` tied 0.
  - SHOW_ERR still entered; `error_active` still asserted.
  - All other behaviour identical.

## Structure
- Package `display_seq_pkg`: state enum (SHOW_A, SHOW_B, SHOW_ERR, 2-bit encoding), `SEL_A`/`SEL_B` constants, and a counter-width function.
- One sub-module, `display_seq_timer`: parameterised cycle counter with clear, enable and terminal-count pulse. Instantiated for timeout, and for blink under the macro.

## Test plan
Bench parameters: `TIMEOUT_CYCLES`=8, `BLINK_HALF_CYCLES`=3.
- Reset, then `view_toggle` with no prior result → `display_select` stays 0.
- `result_valid` (overflow 0) at edge 10 → select 1 from edge 10. With no events, select returns to 0 after edge 18.
- In SHOW_B, `result_valid` at edge 5 after entry → timer restarts; revert happens 8 edges later.
- `result_valid` + `key_press` in the same cycle from SHOW_A → SHOW_B (priority). Then `key_press` → select 0 next edge.
- `result_valid` with overflow 1 → `error_active` 1, select 1. With the macro, blank pattern 0,0,0,1,1,1,0… Without it, blank stays 0. `key_press` → SHOW_A; a subsequent `view_toggle` is ignored (`have_result` cleared).
- `reset_n` low mid-SHOW_ERR while blank=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/display_seq_pkg.sv
// Shared types and helpers for the calculator display sequencer.
// State encoding, mux select constants and counter sizing.
package display_seq_pkg;

    typedef enum logic [1:0] {
        SHOW_A   = 2'd0,
        SHOW_B   = 2'd1,
        SHOW_ERR = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Enough bits to hold the value n itself; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(longint'(n) + 1);
    endfunction

endpackage

// File: rtl/display_seq_timer.sv
// Saturating cycle counter with synchronous clear, enable and terminal-count flag.
// tc is combinational: high while enabled and the count sits at TERMINAL-1.
module display_seq_timer
    import display_seq_pkg::*;
#(
    parameter int unsigned TERMINAL = 8,
    parameter int          W        = cnt_width(TERMINAL)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'((TERMINAL == 0) ? 0 : TERMINAL - 1);
    localparam logic [W-1:0] SAT  = W'(TERMINAL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // TERMINAL of zero means the counter never expires.
    assign tc = en && (TERMINAL != 0) && (cnt_q == LAST);

endmodule

// File: rtl/display_sequencer.sv
// Display mux select controller: operand (A) / result (B) / overflow error view.
// Optional error blink compiled in with DISPLAY_SEQ_BLINK_EN; otherwise display_blank stays 0.
module display_sequencer
    import display_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 250_000_000,
    parameter int unsigned BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_press,
    input  logic result_valid,
    input  logic result_overflow,
    input  logic view_toggle,
    output logic display_select,
    output logic display_blank,
    output logic error_active
);

    state_t state_q, state_d;
    logic   have_q, have_d;
    logic   sel_q, sel_d;
    logic   err_q, err_d;
    logic   blank_q, blank_d;

    logic any_evt;
    logic to_en, to_clr, to_tc;

    assign any_evt = key_press | result_valid | view_toggle;
    assign to_en   = (state_q == SHOW_B);
    assign to_clr  = !to_en || any_evt;

    display_seq_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (to_clr),
        .en      (to_en),
        .tc      (to_tc)
    );

    // Priority: result_valid, then key_press, then view_toggle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SHOW_A: begin
                if (result_valid) begin
                    state_d = result_overflow ? SHOW_ERR : SHOW_B;
                end else if (key_press) begin
                    state_d = SHOW_A;
                end else if (view_toggle && have_q) begin
                    state_d = SHOW_B;
                end
            end
            SHOW_B: begin
                if (result_valid) begin
                    state_d = result_overflow ? SHOW_ERR : SHOW_B;
                end else if (key_press || view_toggle) begin
                    state_d = SHOW_A;
                end else if (to_tc) begin
                    state_d = SHOW_A;
                end
            end
            SHOW_ERR: begin
                if (result_valid) begin
                    if (!result_overflow) state_d = SHOW_B;
                end else if (key_press || view_toggle) begin
                    state_d = SHOW_A;
                end
            end
            default: state_d = SHOW_A;
        endcase
    end

    always_comb begin
        have_d = have_q;
        if ((state_q == SHOW_ERR) && (state_d != SHOW_ERR)) have_d = 1'b0;
        if (result_valid && !result_overflow) have_d = 1'b1;
        sel_d = (state_d == SHOW_A) ? SEL_A : SEL_B;
        err_d = (state_d == SHOW_ERR);
    end

`ifdef DISPLAY_SEQ_BLINK_EN
    logic blink_en, blink_clr, blink_tc;

    // Counter restarts on entry and wraps each half-period.
    assign blink_en  = (state_q == SHOW_ERR) && (state_d == SHOW_ERR);
    assign blink_clr = !blink_en || blink_tc;

    display_seq_timer #(.TERMINAL(BLINK_HALF_CYCLES)) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (blink_clr),
        .en      (blink_en),
        .tc      (blink_tc)
    );

    always_comb begin
        blank_d = 1'b0;
        if (blink_en) blank_d = blink_tc ? !blank_q : blank_q;
    end
`else
    always_comb begin
        blank_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SHOW_A;
            have_q  <= 1'b0;
            sel_q   <= SEL_A;
            err_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            have_q  <= have_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            blank_q <= blank_d;
        end
    end

    assign display_select = sel_q;
    assign error_active   = err_q;
    assign display_blank  = blank_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized and directed bench for display_sequencer against a view/age reference model.
module tb_display_sequencer;

    localparam int T = 8;
    localparam int H = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic key_press = 1'b0;
    logic result_valid = 1'b0;
    logic result_overflow = 1'b0;
    logic view_toggle = 1'b0;
    logic display_select, display_blank, error_active;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: 0 = operand view, 1 = result view, 2 = error view.
    int m_view = 0;
    bit m_have = 0;
    int m_idle = 0;
    int m_age  = 0;

    always #5 clk = ~clk;

    display_sequencer #(
        .TIMEOUT_CYCLES    (T),
        .BLINK_HALF_CYCLES (H)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .key_press       (key_press),
        .result_valid    (result_valid),
        .result_overflow (result_overflow),
        .view_toggle     (view_toggle),
        .display_select  (display_select),
        .display_blank   (display_blank),
        .error_active    (error_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_view = 0;
        m_have = 0;
        m_idle = 0;
        m_age  = 0;
    endfunction

    function automatic void m_step(input bit kp, input bit rv, input bit ov, input bit vt);
        int prev = m_view;
        bit evt = kp || rv || vt;
        if (rv) begin
            if (!ov) m_view = 1;
            else     m_view = 2;
        end else if (prev == 0) begin
            if (!kp && vt && m_have) m_view = 1;
        end else if (kp || vt) begin
            m_view = 0;
        end
        // Idle time in the result view; reaching T idle cycles reverts.
        if (prev == 1 && m_view == 1 && !evt) begin
            m_idle++;
            if (m_idle == T) m_view = 0;
        end else begin
            m_idle = 0;
        end
        if (prev == 2 && m_view != 2) m_have = 0;
        if (rv && !ov) m_have = 1;
        m_age = (m_view == 2 && prev == 2) ? m_age + 1 : 0;
    endfunction

    function automatic bit m_blank();
`ifdef DISPLAY_SEQ_BLINK_EN
        return (m_view == 2) && (((m_age / H) % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string where);
        chk({where, ".sel"},   display_select, (m_view != 0));
        chk({where, ".err"},   error_active,   (m_view == 2));
        chk({where, ".blank"}, display_blank,  m_blank());
    endtask

    // Drive at the falling edge, model steps on the rising edge, compare at the next falling edge.
    task automatic cyc(input bit kp, input bit rv, input bit ov, input bit vt);
        key_press       = kp;
        result_valid    = rv;
        result_overflow = ov;
        view_toggle     = vt;
        @(posedge clk);
        m_step(kp, rv, ov, vt);
        @(negedge clk);
        key_press       = 1'b0;
        result_valid    = 1'b0;
        result_overflow = 1'b0;
        view_toggle     = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;

        // Toggle with no result is ignored.
        cyc(0, 0, 0, 1);
        idle(8);
        // Result, then full timeout back to operand view.
        cyc(0, 1, 0, 0);
        idle(T + 2);
        // Result restarts the timer mid-way.
        cyc(0, 1, 0, 0);
        idle(4);
        cyc(0, 1, 0, 0);
        idle(T + 1);
        // Toggle to result view with a result on hand, then back.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        // Same-cycle result and key press: result wins; then key press returns to A.
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        // Overflow: error view with blink, exit clears the stored result.
        cyc(0, 1, 1, 0);
        idle(8);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        idle(2);
        // Error view then good result goes straight to the result view.
        cyc(0, 1, 1, 0);
        idle(2);
        cyc(0, 1, 0, 0);
        idle(3);

        // Asynchronous reset while blanked in the error view.
        cyc(0, 1, 1, 0);
        idle(4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.sel",   display_select, 1'b0);
        chk("async_rst.err",   error_active,   1'b0);
        chk("async_rst.blank", display_blank,  1'b0);
        m_reset();
        @(negedge clk);
        check_outputs("in_reset");
        reset_n = 1'b1;
        cyc(0, 0, 0, 1);

        // Random traffic with sparse events so timeouts and blinks occur.
        for (int i = 0; i < 800; i++) begin
            bit kp, rv, ov, vt;
            rv = ($urandom_range(0, 11) == 0);
            ov = ($urandom_range(0, 2) == 0);
            kp = ($urandom_range(0, 9) == 0);
            vt = ($urandom_range(0, 7) == 0);
            cyc(kp, rv, ov, vt);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
